// File: rtl/ram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_sched_pkg
// Brief    : Shared types and the per-layer table for the RAM write scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ram_sched_pkg;

    localparam int ADDR_W      = 13;
    localparam int FIDX_W      = 9;
    localparam int SIDE_STRIDE = 8;
    localparam int LAYER_W     = 3;
    localparam int WORD_W      = 4;   // word offset within a feature, widest stride is 16
    localparam int SHIFT_W     = 3;
    localparam int NUM_LAYERS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TOP  = 2'd1,
        ST_SIDE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A zero feature count marks a layer as unsupported.
    localparam logic [FIDX_W:0] LAYER_NUM_FEAT [NUM_LAYERS] = '{
        10'd4, 10'd64, 10'd128, 10'd256, 10'd512, 10'd512, 10'd0, 10'd0
    };

    localparam logic [SHIFT_W-1:0] LAYER_TOP_SHIFT [NUM_LAYERS] = '{
        3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0
    };

endpackage
`default_nettype wire

// File: rtl/layer_cfg_lut.sv
`default_nettype none
// ============================================================================
// Module   : layer_cfg_lut
// Brief    : Maps a conv layer index to its last feature, top stride shift
//            and supported flag.
// Revision : 1.0 - initial release
// ============================================================================
module layer_cfg_lut #(
    parameter int FIDX_W = ram_sched_pkg::FIDX_W
) (
    input  logic [ram_sched_pkg::LAYER_W-1:0] i_layer,
    output logic [FIDX_W-1:0]                 o_last_feature,
    output logic [ram_sched_pkg::SHIFT_W-1:0] o_top_shift,
    output logic                              o_supported
);
    import ram_sched_pkg::*;

    logic [ram_sched_pkg::FIDX_W:0] w_num_feat;

    always_comb begin
        w_num_feat     = LAYER_NUM_FEAT[i_layer];
        o_supported    = (w_num_feat != '0);
        o_last_feature = o_supported ? FIDX_W'(w_num_feat - 1'b1) : '0;
        o_top_shift    = LAYER_TOP_SHIFT[i_layer];
    end

endmodule
`default_nettype wire

// File: rtl/ram_wr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ram_wr_scheduler
// Brief    : Sequences write-back of one conv layer's features into the top
//            and side feature RAMs, one registered write per accepted beat.
// Revision : 1.0 - initial release
// ============================================================================
module ram_wr_scheduler #(
    parameter int ADDR_W      = ram_sched_pkg::ADDR_W,
    parameter int FIDX_W      = ram_sched_pkg::FIDX_W,
    parameter int SIDE_STRIDE = ram_sched_pkg::SIDE_STRIDE
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [2:0]        conv_layer_index_i,
    input  logic              abort_i,
    input  logic              data_valid_i,
    output logic              data_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [FIDX_W-1:0] feature_index_o,
    output logic              top_we_o,
    output logic [ADDR_W-1:0] top_addr_o,
    output logic              side_we_o,
    output logic [ADDR_W-1:0] side_addr_o
);
    import ram_sched_pkg::*;

    localparam int                c_side_shift = $clog2(SIDE_STRIDE);
    localparam logic [WORD_W-1:0] c_side_last  = WORD_W'(SIDE_STRIDE - 1);

    state_t              r_state, w_state_next;
    logic [FIDX_W-1:0]   r_feat, w_feat_next;
    logic [WORD_W-1:0]   r_word, w_word_next;
    logic [FIDX_W-1:0]   r_last_feat, w_last_feat_next;
    logic [SHIFT_W-1:0]  r_top_shift, w_top_shift_next;
    logic                r_top_we, w_top_we_next;
    logic [ADDR_W-1:0]   r_top_addr, w_top_addr_next;
    logic                r_side_we, w_side_we_next;
    logic [ADDR_W-1:0]   r_side_addr, w_side_addr_next;
    logic                r_done, w_done_next;
    logic                r_err, w_err_next;
    logic                r_busy, w_busy_next;

    logic [FIDX_W-1:0]   w_lut_last;
    logic [SHIFT_W-1:0]  w_lut_shift;
    logic                w_lut_supported;
    logic                w_ready, w_beat, w_top_word_last;
    logic [ADDR_W-1:0]   w_top_addr_calc, w_side_addr_calc;

    // Config is captured from the live layer input at start, so one LUT suffices.
    layer_cfg_lut #(
        .FIDX_W (FIDX_W)
    ) u_layer_cfg_lut (
        .i_layer        (conv_layer_index_i),
        .o_last_feature (w_lut_last),
        .o_top_shift    (w_lut_shift),
        .o_supported    (w_lut_supported)
    );

    assign w_ready          = (r_state == ST_TOP) || (r_state == ST_SIDE);
    assign w_beat           = w_ready && data_valid_i;
    assign w_top_addr_calc  = (ADDR_W'(r_feat) << r_top_shift) + ADDR_W'(r_word);
    assign w_side_addr_calc = (ADDR_W'(r_feat) << c_side_shift) + ADDR_W'(r_word);
    // One extra bit keeps stride-1 exact when the stride equals 2**WORD_W.
    assign w_top_word_last  = ({1'b0, r_word} ==
                               (((WORD_W+1)'(1) << r_top_shift) - (WORD_W+1)'(1)));

    always_comb begin
        w_state_next     = r_state;
        w_feat_next      = r_feat;
        w_word_next      = r_word;
        w_last_feat_next = r_last_feat;
        w_top_shift_next = r_top_shift;
        w_top_we_next    = 1'b0;
        w_top_addr_next  = r_top_addr;
        w_side_we_next   = 1'b0;
        w_side_addr_next = r_side_addr;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_lut_supported) begin
                        w_state_next     = ST_TOP;
                        w_feat_next      = '0;
                        w_word_next      = '0;
                        w_last_feat_next = w_lut_last;
                        w_top_shift_next = w_lut_shift;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_TOP: begin
                if (w_beat) begin
                    w_top_we_next   = 1'b1;
                    w_top_addr_next = w_top_addr_calc;
                    if (w_top_word_last) begin
                        w_word_next  = '0;
                        w_state_next = ST_SIDE;
                    end else begin
                        w_word_next = r_word + 1'b1;
                    end
                end
            end
            ST_SIDE: begin
                if (w_beat) begin
                    w_side_we_next   = 1'b1;
                    w_side_addr_next = w_side_addr_calc;
                    if (r_word == c_side_last) begin
                        w_word_next = '0;
                        if (r_feat == r_last_feat) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_feat_next  = r_feat + 1'b1;
                            w_state_next = ST_TOP;
                        end
                    end else begin
                        w_word_next = r_word + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Abort discards everything, including a beat accepted this cycle.
        if (abort_i) begin
            w_state_next   = ST_IDLE;
            w_feat_next    = '0;
            w_word_next    = '0;
            w_top_we_next  = 1'b0;
            w_side_we_next = 1'b0;
            w_done_next    = 1'b0;
            w_err_next     = 1'b0;
        end

        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_feat      <= '0;
            r_word      <= '0;
            r_last_feat <= '0;
            r_top_shift <= '0;
            r_top_we    <= 1'b0;
            r_top_addr  <= '0;
            r_side_we   <= 1'b0;
            r_side_addr <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_feat      <= w_feat_next;
            r_word      <= w_word_next;
            r_last_feat <= w_last_feat_next;
            r_top_shift <= w_top_shift_next;
            r_top_we    <= w_top_we_next;
            r_top_addr  <= w_top_addr_next;
            r_side_we   <= w_side_we_next;
            r_side_addr <= w_side_addr_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_busy      <= w_busy_next;
        end
    end

    assign data_ready_o    = w_ready;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;
    assign feature_index_o = r_feat;
    assign top_we_o        = r_top_we;
    assign top_addr_o      = r_top_addr;
    assign side_we_o       = r_side_we;
    assign side_addr_o     = r_side_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_wr_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ram_wr_scheduler
// Brief    : Self-checking bench for ram_wr_scheduler against a write-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_wr_scheduler;

    typedef struct packed {
        logic        side;
        logic [12:0] addr;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  conv_layer_index_i = 3'd0;
    logic        abort_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o, busy_o, done_o, err_o;
    logic [8:0]  feature_index_o;
    logic        top_we_o, side_we_o;
    logic [12:0] top_addr_o, side_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    wr_t obs_q[$];
    wr_t exp_q[$];
    int  cyc = 0, last_we_cyc = 0, done_cyc = 0, done_cnt = 0;
    int  lat_err = 0, both_err = 0, acc_cnt = 0;
    bit  acc_prev = 1'b0;

    always #5 clk_i = ~clk_i;

    ram_wr_scheduler dut (
        .clk_i              (clk_i),
        .rst_n_i            (rst_n_i),
        .start_i            (start_i),
        .conv_layer_index_i (conv_layer_index_i),
        .abort_i            (abort_i),
        .data_valid_i       (data_valid_i),
        .data_ready_o       (data_ready_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .err_o              (err_o),
        .feature_index_o    (feature_index_o),
        .top_we_o           (top_we_o),
        .top_addr_o         (top_addr_o),
        .side_we_o          (side_we_o),
        .side_addr_o        (side_addr_o)
    );

    // Beats that must produce a write one cycle later.
    always @(posedge clk_i) begin
        acc_prev = rst_n_i && data_valid_i && data_ready_o && !abort_i;
        if (acc_prev) acc_cnt++;
    end

    always @(negedge clk_i) begin
        cyc++;
        if (rst_n_i) begin
            if ((top_we_o | side_we_o) !== acc_prev) lat_err++;
            if (top_we_o && side_we_o) both_err++;
            if (top_we_o) obs_q.push_back(wr_t'{1'b0, top_addr_o});
            if (side_we_o) obs_q.push_back(wr_t'{1'b1, side_addr_o});
            if (top_we_o | side_we_o) last_we_cyc = cyc;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    function automatic wr_t mk(input bit side, input int addr);
        wr_t e;
        e.side = side;
        e.addr = 13'(addr);
        return e;
    endfunction

    // Write list straight from the layer table: per feature, stride top words then 8 side words.
    function automatic void build_expected(input int layer);
        int nf, st;
        case (layer)
            0: begin nf = 4;   st = 16; end
            1: begin nf = 64;  st = 16; end
            2: begin nf = 128; st = 8;  end
            3: begin nf = 256; st = 4;  end
            4: begin nf = 512; st = 2;  end
            default: begin nf = 512; st = 1; end
        endcase
        exp_q.delete();
        for (int f = 0; f < nf; f++) begin
            for (int w = 0; w < st; w++) exp_q.push_back(mk(1'b0, f * st + w));
            for (int w = 0; w < 8; w++)  exp_q.push_back(mk(1'b1, f * 8 + w));
        end
    endfunction

    function automatic int first_diff(input int n);
        for (int i = 0; i < n; i++) begin
            if (i >= obs_q.size() || i >= exp_q.size()) return i;
            if (obs_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid
    task automatic run_layer(input int layer, input int mode, input int budget, output bit timed_out);
        int d0, n;
        d0 = done_cnt;
        start_i = 1'b1;
        conv_layer_index_i = 3'(layer);
        tick();
        start_i = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            case (mode)
                0: data_valid_i = 1'b1;
                1: data_valid_i = n[0];
                default: data_valid_i = 1'($urandom_range(0, 1));
            endcase
            tick();
            n++;
        end
        data_valid_i = 1'b0;
        timed_out = (done_cnt == d0);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if ({busy_o, done_o, err_o, data_ready_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy_o, done_o, err_o, data_ready_o});
        end
        n_checks++;
        if ({top_we_o, side_we_o, top_addr_o, side_addr_o, feature_index_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: top_addr=%0d side_addr=%0d fidx=%0d expected all 0",
                     top_addr_o, side_addr_o, feature_index_o);
        end
        rst_n_i = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_l0();
        int d0, l0, b0, k, bad;
        bit to;
        build_expected(0);
        obs_q.delete();
        d0 = done_cnt; l0 = lat_err; b0 = both_err;
        run_layer(0, 0, 500, to);
        repeat (4) tick();
        n_checks++;
        if (to) begin n_fail++; $display("FAIL l0_timeout: done never seen, expected done"); end
        n_checks++;
        if (obs_q.size() != 96) begin n_fail++; $display("FAIL l0_count: got %0d writes expected 96", obs_q.size()); end
        k = first_diff(96);
        n_checks++;
        if (k != -1) begin n_fail++; $display("FAIL l0_seq: first difference at write %0d got %h expected %h", k, obs_q[k], exp_q[k]); end
        n_checks++;
        if (obs_q[0] !== mk(1'b0, 0)) begin n_fail++; $display("FAIL l0_first: got %h expected top addr 0", obs_q[0]); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (obs_q[16 + i] !== mk(1'b1, i)) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL l0_f0_side: got %0d wrong side writes expected 0", bad); end
        n_checks++;
        if (obs_q[24] !== mk(1'b0, 16)) begin n_fail++; $display("FAIL l0_f1_top: got %h expected top addr 16", obs_q[24]); end
        n_checks++;
        if (obs_q[87] !== mk(1'b0, 63)) begin n_fail++; $display("FAIL l0_last_top: got %h expected top addr 63", obs_q[87]); end
        n_checks++;
        if (obs_q[95] !== mk(1'b1, 31)) begin n_fail++; $display("FAIL l0_last_side: got %h expected side addr 31", obs_q[95]); end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL l0_done_cnt: got %0d expected 1", done_cnt - d0); end
        n_checks++;
        if (done_cyc != last_we_cyc + 1) begin n_fail++; $display("FAIL l0_done_lat: got %0d expected %0d", done_cyc, last_we_cyc + 1); end
        n_checks++;
        if (lat_err != l0 || both_err != b0) begin
            n_fail++; $display("FAIL l0_timing: got lat=%0d both=%0d expected 0 0", lat_err - l0, both_err - b0);
        end
    endtask

    task automatic test_l5();
        int d0, k;
        bit to;
        build_expected(5);
        obs_q.delete();
        d0 = done_cnt;
        run_layer(5, 0, 6000, to);
        repeat (3) tick();
        n_checks++;
        if (to || obs_q.size() != 4608) begin
            n_fail++; $display("FAIL l5_count: got %0d writes timeout=%0d expected 4608", obs_q.size(), to);
        end
        k = first_diff(4608);
        n_checks++;
        if (k != -1) begin n_fail++; $display("FAIL l5_seq: first difference at write %0d got %h expected %h", k, obs_q[k], exp_q[k]); end
        n_checks++;
        if (obs_q[4599] !== mk(1'b0, 511)) begin n_fail++; $display("FAIL l5_top511: got %h expected top addr 511", obs_q[4599]); end
        n_checks++;
        if (obs_q[4600] !== mk(1'b1, 4088) || obs_q[4607] !== mk(1'b1, 4095)) begin
            n_fail++; $display("FAIL l5_side_end: got %h..%h expected side 4088..4095", obs_q[4600], obs_q[4607]);
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL l5_done: got %0d pulses expected 1", done_cnt - d0); end
    endtask

    task automatic test_l2_toggle();
        int l0, k;
        bit to;
        build_expected(2);
        obs_q.delete();
        l0 = lat_err;
        run_layer(2, 1, 6000, to);
        repeat (3) tick();
        k = first_diff(2048);
        n_checks++;
        if (to || obs_q.size() != 2048 || k != -1) begin
            n_fail++; $display("FAIL l2_seq: got %0d writes first diff %0d expected 2048 and -1", obs_q.size(), k);
        end
        n_checks++;
        if (obs_q[48] !== mk(1'b0, 24) || obs_q[55] !== mk(1'b0, 31)) begin
            n_fail++; $display("FAIL l2_f3_top: got %h..%h expected top 24..31", obs_q[48], obs_q[55]);
        end
        n_checks++;
        if (lat_err != l0) begin n_fail++; $display("FAIL l2_latency: got %0d bad cycles expected 0", lat_err - l0); end
    endtask

    task automatic test_l1_random();
        int l0, b0, k;
        bit to;
        build_expected(1);
        obs_q.delete();
        l0 = lat_err; b0 = both_err;
        run_layer(1, 2, 20000, to);
        repeat (3) tick();
        k = first_diff(1536);
        n_checks++;
        if (to || obs_q.size() != 1536 || k != -1) begin
            n_fail++; $display("FAIL l1_rand_seq: got %0d writes first diff %0d expected 1536 and -1", obs_q.size(), k);
        end
        n_checks++;
        if (lat_err != l0 || both_err != b0) begin
            n_fail++; $display("FAIL l1_rand_timing: got lat=%0d both=%0d expected 0 0", lat_err - l0, both_err - b0);
        end
    endtask

    task automatic test_err();
        int d0;
        obs_q.delete();
        d0 = done_cnt;
        for (int layer = 6; layer < 8; layer++) begin
            start_i = 1'b1;
            conv_layer_index_i = 3'(layer);
            tick();
            start_i = 1'b0;
            data_valid_i = 1'b1;
            n_checks++;
            if (err_o !== 1'b1 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL err_pulse_l%0d: got err=%b busy=%b expected 1 0", layer, err_o, busy_o);
            end
            tick();
            n_checks++;
            if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_width_l%0d: got %b expected 0", layer, err_o); end
            repeat (5) tick();
            data_valid_i = 1'b0;
        end
        n_checks++;
        if (obs_q.size() != 0 || done_cnt != d0) begin
            n_fail++; $display("FAIL err_no_write: got %0d writes %0d dones expected 0 0", obs_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_busy_start();
        int d0, n, k;
        build_expected(0);
        obs_q.delete();
        d0 = done_cnt;
        start_i = 1'b1;
        conv_layer_index_i = 3'd0;
        tick();
        start_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b expected 1", busy_o); end
        data_valid_i = 1'b1;
        repeat (10) tick();
        start_i = 1'b1;
        conv_layer_index_i = 3'd1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 500) begin tick(); n++; end
        data_valid_i = 1'b0;
        repeat (3) tick();
        k = first_diff(96);
        n_checks++;
        if (obs_q.size() != 96 || k != -1 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL busy_start_ignored: got %0d writes diff %0d dones %0d expected 96 -1 1",
                               obs_q.size(), k, done_cnt - d0);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", busy_o); end
    endtask

    task automatic test_abort();
        int d0, a0, k, n;
        bit to;
        build_expected(3);
        obs_q.delete();
        d0 = done_cnt;
        a0 = acc_cnt;
        start_i = 1'b1;
        conv_layer_index_i = 3'd3;
        tick();
        start_i = 1'b0;
        data_valid_i = 1'b1;
        n = 0;
        // Beat 127 is feature 10, side word 3 (12 beats per feature).
        while (acc_cnt - a0 != 127 && n < 400) begin tick(); n++; end
        n_checks++;
        if (feature_index_o !== 9'd10 || acc_cnt - a0 != 127) begin
            n_fail++; $display("FAIL abort_point: got fidx=%0d beats=%0d expected 10 127", feature_index_o, acc_cnt - a0);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || data_ready_o !== 1'b0 || feature_index_o !== 9'd0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b ready=%b fidx=%0d expected 0 0 0", busy_o, data_ready_o, feature_index_o);
        end
        repeat (20) tick();
        data_valid_i = 1'b0;
        k = first_diff(127);
        n_checks++;
        if (obs_q.size() != 127 || k != -1) begin
            n_fail++; $display("FAIL abort_writes: got %0d writes diff %0d expected 127 -1", obs_q.size(), k);
        end
        n_checks++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0); end
        obs_q.delete();
        run_layer(3, 0, 5000, to);
        repeat (3) tick();
        k = first_diff(3072);
        n_checks++;
        if (to || obs_q.size() != 3072 || k != -1 || obs_q[0] !== mk(1'b0, 0)) begin
            n_fail++; $display("FAIL abort_restart: got %0d writes diff %0d first %h expected 3072 -1 top 0",
                               obs_q.size(), k, obs_q[0]);
        end
    endtask

    task automatic test_async_reset();
        int nb, k;
        build_expected(1);
        obs_q.delete();
        start_i = 1'b1;
        conv_layer_index_i = 3'd1;
        tick();
        start_i = 1'b0;
        data_valid_i = 1'b1;
        repeat (30) tick();
        n_checks++;
        if (top_we_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got top_we=%b busy=%b expected 1 1", top_we_o, busy_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, data_ready_o, top_we_o, side_we_o, top_addr_o, side_addr_o, feature_index_o} !== '0) begin
            n_fail++; $display("FAIL rst_async: got busy=%b ready=%b top_we=%b top_addr=%0d fidx=%0d expected all 0",
                               busy_o, data_ready_o, top_we_o, top_addr_o, feature_index_o);
        end
        nb = obs_q.size();
        repeat (2) tick();
        rst_n_i = 1'b1;
        repeat (30) tick();
        data_valid_i = 1'b0;
        k = first_diff(nb);
        n_checks++;
        if (obs_q.size() != nb || k != -1 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle_after: got %0d writes (was %0d) diff %0d busy=%b expected no new writes, busy 0",
                               obs_q.size(), nb, k, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_l0();
        test_l5();
        test_l2_toggle();
        test_l1_random();
        test_err();
        test_busy_start();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
